// File: rtl/icache_dm_param.sv
// Direct-mapped instruction cache between instruction fetch and the memory controller.
// One word per line; misses refill through a level req / pulse ack handshake.
module icache_dm_param #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_BITS  = 7,
  parameter int OFFSET_BITS = 2,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_ready_o,
  output logic [DATA_WIDTH-1:0] if_inst_o,
  input  logic                  abort_i,
  input  logic                  flush_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic [CNT_WIDTH-1:0]  hit_cnt_o,
  output logic [CNT_WIDTH-1:0]  miss_cnt_o
);
  localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
  localparam int LINES = 1 << INDEX_BITS;
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'((1 << OFFSET_BITS) - 1);

  typedef enum logic {IDLE, REFILL} state_t;

  state_t                 state;
  logic [LINES-1:0]       valid;
  logic [TAG_W-1:0]       tag_mem  [LINES];
  logic [DATA_WIDTH-1:0]  data_mem [LINES];

  logic [INDEX_BITS-1:0]  lk_idx, rf_idx;
  logic [TAG_W-1:0]       lk_tag, rf_tag;
  logic                   lk_hit, sample, rf_write;

  assign lk_idx = if_addr_i[OFFSET_BITS +: INDEX_BITS];
  assign lk_tag = if_addr_i[ADDR_WIDTH-1 -: TAG_W];
  assign lk_hit = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);
  assign sample = if_req_i && !if_ready_o && !abort_i && !flush_i;

  // The refill target is the latched fetch address driven on mem_addr_o.
  assign rf_idx   = mem_addr_o[OFFSET_BITS +: INDEX_BITS];
  assign rf_tag   = mem_addr_o[ADDR_WIDTH-1 -: TAG_W];
  assign rf_write = (state == REFILL) && mem_ack_i && !flush_i;

  // Arrays carry no reset; valid bits alone decide whether a line is usable.
  always_ff @(posedge clk) begin
    if (rf_write) begin
      tag_mem[rf_idx]  <= rf_tag;
      data_mem[rf_idx] <= mem_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      valid      <= '0;
      if_ready_o <= 1'b0;
      if_inst_o  <= '0;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if_ready_o <= 1'b0;
      if (flush_i) valid <= '0;
      case (state)
        IDLE: begin
          if (sample) begin
            if (lk_hit) begin
              if_ready_o <= 1'b1;
              if_inst_o  <= data_mem[lk_idx];
              if (hit_cnt_o != '1) hit_cnt_o <= hit_cnt_o + CNT_WIDTH'(1);
            end else begin
              mem_req_o  <= 1'b1;
              mem_addr_o <= if_addr_i & WORD_MASK;
              if (miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + CNT_WIDTH'(1);
              state      <= REFILL;
            end
          end
        end
        REFILL: begin
          if (flush_i || abort_i) begin
            // Abort keeps good ack data; flush discards it (valid already cleared).
            if (!flush_i && mem_ack_i) valid[rf_idx] <= 1'b1;
            mem_req_o <= 1'b0;
            state     <= IDLE;
          end else if (mem_ack_i) begin
            valid[rf_idx] <= 1'b1;
            if_ready_o    <= 1'b1;
            if_inst_o     <= mem_data_i;
            mem_req_o     <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_dm_param.sv
// Scoreboard bench for icache_dm_param: expected fetch results are queued when a
// fetch is driven and popped when the cache raises if_ready_o.
module tb_icache_dm_param;
  localparam int AW = 32, DW = 32, CW = 4;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          if_req_i = 1'b0, abort_i = 1'b0, flush_i = 1'b0, mem_ack_i = 1'b0;
  logic [AW-1:0] if_addr_i = '0;
  logic [DW-1:0] mem_data_i = '0;
  logic          if_ready_o, mem_req_o;
  logic [DW-1:0] if_inst_o;
  logic [AW-1:0] mem_addr_o;
  logic [CW-1:0] hit_cnt_o, miss_cnt_o;

  icache_dm_param #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INDEX_BITS(7), .OFFSET_BITS(2),
                    .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_ready_o(if_ready_o), .if_inst_o(if_inst_o), .abort_i(abort_i), .flush_i(flush_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
    .mem_data_i(mem_data_i), .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int exp_hit = 0, exp_miss = 0;
  logic [DW-1:0] sb_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] sat(input int n);
    return (n > 15) ? 4'hF : CW'(n);
  endfunction

  // Every ready pulse must match a queued expectation; a pulse with none queued is an error.
  always @(negedge clk) begin
    if (rst_n && if_ready_o) begin
      if (sb_q.size() == 0) chk("spurious_ready", 1, 0);
      else chk("if_inst", if_inst_o, sb_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_cnt();
    chk("hit_cnt", hit_cnt_o, sat(exp_hit));
    chk("miss_cnt", miss_cnt_o, sat(exp_miss));
  endtask

  task automatic fetch_hit(input logic [AW-1:0] a, input logic [DW-1:0] d);
    if_req_i = 1'b1; if_addr_i = a; sb_q.push_back(d); exp_hit++;
    tick();
    chk("hit_ready", if_ready_o, 1);
    chk("hit_no_memreq", mem_req_o, 0);
    if_req_i = 1'b0;
    tick();
    chk_cnt();
  endtask

  task automatic fetch_miss(input logic [AW-1:0] a, input logic [DW-1:0] d, input int dly);
    if_req_i = 1'b1; if_addr_i = a; exp_miss++;
    tick();
    chk("miss_req", mem_req_o, 1);
    chk("miss_addr", mem_addr_o, a & 32'hFFFF_FFFC);
    for (int i = 0; i < dly; i++) begin
      tick();
      chk("req_hold", {mem_req_o, mem_addr_o}, {1'b1, a & 32'hFFFF_FFFC});
    end
    mem_ack_i = 1'b1; mem_data_i = d; sb_q.push_back(d);
    tick();
    mem_ack_i = 1'b0;
    chk("refill_ready", if_ready_o, 1);
    chk("req_drop", mem_req_o, 0);
    if_req_i = 1'b0;
    tick();
    chk_cnt();
  endtask

  // Start a miss and leave the cache in REFILL.
  task automatic start_miss(input logic [AW-1:0] a);
    if_req_i = 1'b1; if_addr_i = a; exp_miss++;
    tick();
    chk("start_req", mem_req_o, 1);
  endtask

  initial begin
    #12;
    chk("rst_ready", if_ready_o, 0);
    chk("rst_req", mem_req_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_inst", if_inst_o, 0);
    chk_cnt();
    tick(); rst_n = 1'b1; tick();

    // 1/2: cold miss, then hit (also via an unaligned address in the same word)
    fetch_miss(32'h100, 32'h00A0_0093, 2);
    fetch_hit(32'h100, 32'h00A0_0093);
    fetch_hit(32'h102, 32'h00A0_0093);

    // 3: conflicting tag on the same index evicts the line
    fetch_miss(32'h300, 32'h1111_2222, 0);
    fetch_miss(32'h100, 32'h3333_4444, 1);
    fetch_hit(32'h100, 32'h3333_4444);

    // 4: abort before ack; a late ack is ignored; refetch misses
    start_miss(32'h204);
    abort_i = 1'b1; if_req_i = 1'b0;
    tick();
    abort_i = 1'b0;
    chk("abort_req", mem_req_o, 0);
    mem_ack_i = 1'b1; mem_data_i = 32'hDEAD_BEEF;
    tick();
    mem_ack_i = 1'b0;
    tick();
    chk_cnt();
    fetch_miss(32'h204, 32'h5555_6666, 0);

    // 5a: abort with simultaneous ack still writes the line
    start_miss(32'h208);
    abort_i = 1'b1; mem_ack_i = 1'b1; mem_data_i = 32'h7777_8888; if_req_i = 1'b0;
    tick();
    abort_i = 1'b0; mem_ack_i = 1'b0;
    chk("abort_ack_req", mem_req_o, 0);
    tick();
    fetch_hit(32'h208, 32'h7777_8888);

    // 5b: flush with simultaneous ack discards it
    start_miss(32'h20C);
    flush_i = 1'b1; mem_ack_i = 1'b1; mem_data_i = 32'h9999_AAAA; if_req_i = 1'b0;
    tick();
    flush_i = 1'b0; mem_ack_i = 1'b0;
    chk("flush_ack_req", mem_req_o, 0);
    tick();
    fetch_miss(32'h20C, 32'hBBBB_CCCC, 0);

    // 6: warm four lines, flush, everything misses (miss counter saturates here)
    for (int i = 0; i < 4; i++) fetch_miss(32'h400 + 32'(4*i), 32'hC000_0000 + 32'(i), 0);
    for (int i = 0; i < 4; i++) fetch_hit(32'h400 + 32'(4*i), 32'hC000_0000 + 32'(i));
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    for (int i = 0; i < 4; i++) fetch_miss(32'h400 + 32'(4*i), 32'hD000_0000 + 32'(i), 0);
    chk("miss_saturated", miss_cnt_o, 4'hF);

    // 6: reset during a refill drops mem_req_o immediately
    start_miss(32'h500);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", mem_req_o, 0);
    exp_hit = 0; exp_miss = 0;
    chk_cnt();
    if_req_i = 1'b0;
    tick(); rst_n = 1'b1; tick();
    fetch_miss(32'h100, 32'hE000_0001, 0);

    repeat (2) tick();
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
